inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameters: col, default 8, PE array columns; len_nij, default 64, activation vectors per pass; gap, default 10, idle cycles between phases.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run one kij pass; sampled only in IDLE.
REQ-005 mode  input  1  0 = 4b/4b (one weight block), 1 = 2b/4b (two weight blocks); latched at start.
REQ-006 pmem_base  input  11  first psum SRAM address for this pass; latched at start.
REQ-007 ofifo_valid  input  1  core OFIFO has data ready.
REQ-008 inst  output  34  registered core instruction bus: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-011 Idle word: CEN/WEN of both SRAMs = 1, all other bits 0 (34'h1800C0000); inst SHALL equal the idle word in IDLE, GAP and WAIT states.
REQ-012 acc, ififo_wr, ififo_rd, WEN_xmem SHALL be 0, 0, 0, 1 in every state; the block never writes xmem.
REQ-013 States in order: IDLE, W_L0, W_TAIL, W_LOAD, GAP1, A_L0, A_TAIL, EXEC_PRE, EXEC, GAP2, WAIT_OV, DRAIN_PRE, DRAIN, DONE, then IDLE.
REQ-014 IDLE -> W_L0 on the first edge with start=1; mode and pmem_base latched on that edge.
REQ-015 W_L0: NW = col+1 (mode 0) or 2*(col+1) (mode 1) cycles; CEN_xmem=0, l0_wr=1, A_xmem = 1024+k for k = 0..NW-1.
REQ-016 W_TAIL: 1 cycle; l0_wr=1, CEN_xmem=1, A_xmem=0 (final SRAM read lands in L0).
REQ-017 W_LOAD: NL = 2*col (mode 0) or 4*col (mode 1) cycles; l0_rd=1, load=1.
REQ-018 GAP1 and GAP2: exactly gap cycles each at the idle word.
REQ-019 A_L0: len_nij cycles; CEN_xmem=0, l0_wr=1, A_xmem = k for k = 0..len_nij-1.
REQ-020 A_TAIL: 1 cycle; l0_wr=1, CEN_xmem=1, A_xmem=0.
REQ-021 EXEC_PRE: 1 cycle, l0_rd=1, execute=0; EXEC: len_nij cycles, l0_rd=1, execute=1.
REQ-022 WAIT_OV: hold until ofifo_valid=1 (no timeout); the edge that samples ofifo_valid=1 moves to DRAIN_PRE.
REQ-023 DRAIN_PRE: 1 cycle, ofifo_rd=1, pmem disabled.
REQ-024 DRAIN: len_nij cycles; ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = pmem_base+k (mod 2^11, wraps 2047 -> 0).
REQ-025 DONE: 1 cycle at the idle word, done=1, busy=1; next edge returns to IDLE.
REQ-026 start asserted while busy SHALL be ignored and not queued; start in the DONE cycle is also ignored.
REQ-027 Phase counters are 7 bits wide, clear on every state entry, and compare to terminal count minus 1.
REQ-028 Mode 0 pass length from start edge to done pulse: 9+1+16+10+64+1+1+64+10+W+1+64+1 cycles, W = WAIT_OV cycles (>=1).

Reset
REQ-029 When reset=1 at an edge: state=IDLE, all counters=0, latched mode=0, latched base=0, inst=34'h1800C0000, busy=0, done=0.
REQ-030 Reset SHALL take priority over start and abandon a pass mid-operation in any state, with no further SRAM or FIFO strobes issued.

Verification
REQ-031 Mode 0, base 0, ofifo_valid tied 1 -> 9 weight reads at 1024..1032, 16 load cycles, 64 activation reads at 0..63, 64 execute cycles, 64 pmem writes at 0..63, done after 242 cycles.
REQ-032 Mode 1 -> 18 weight reads at 1024..1041 and 32 load cycles; all other phases identical to mode 0.
REQ-033 ofifo_valid held 0 for 50 cycles in WAIT_OV -> inst stays at the idle word and busy=1 throughout; drain begins 1 cycle after valid rises.
REQ-034 pmem_base=2000 -> writes at 2000..2047 then wrap to 0..15.
REQ-035 Reset pulsed during EXEC -> next inst is 34'h1800C0000 and busy=0; a new start runs a full pass correctly.
REQ-036 start pulsed during A_L0 and during DONE -> no second pass, and exactly one done pulse.

Source files
------------

// File: rtl/inst_sequencer.sv
// Instruction sequencer: walks the core through one kij pass (weight load, activation load,
// execute, psum drain) and presents each step as a registered 34-bit instruction word.
module inst_sequencer #(
    parameter int col     = 8,
    parameter int len_nij = 64,
    parameter int gap     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [10:0] pmem_base,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] W_L0      = 4'd1;
    localparam logic [3:0] W_TAIL    = 4'd2;
    localparam logic [3:0] W_LOAD    = 4'd3;
    localparam logic [3:0] GAP1      = 4'd4;
    localparam logic [3:0] A_L0      = 4'd5;
    localparam logic [3:0] A_TAIL    = 4'd6;
    localparam logic [3:0] EXEC_PRE  = 4'd7;
    localparam logic [3:0] EXEC      = 4'd8;
    localparam logic [3:0] GAP2      = 4'd9;
    localparam logic [3:0] WAIT_OV   = 4'd10;
    localparam logic [3:0] DRAIN_PRE = 4'd11;
    localparam logic [3:0] DRAIN     = 4'd12;
    localparam logic [3:0] DONE      = 4'd13;

    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

    // Terminal counts are stored minus one so the last cycle of a phase is cnt == tc.
    localparam logic [6:0] TC_W_M0  = 7'(col);
    localparam logic [6:0] TC_W_M1  = 7'(2 * (col + 1) - 1);
    localparam logic [6:0] TC_LD_M0 = 7'(2 * col - 1);
    localparam logic [6:0] TC_LD_M1 = 7'(4 * col - 1);
    localparam logic [6:0] TC_GAP   = 7'(gap - 1);
    localparam logic [6:0] TC_LEN   = 7'(len_nij - 1);

    logic [3:0]  state, next_state;
    logic [6:0]  cnt, next_cnt;
    logic        mode_q;
    logic [10:0] base_q;
    logic [33:0] next_inst;
    logic [6:0]  tc_w, tc_ld;
    logic        counted;

    assign tc_w  = mode_q ? TC_W_M1 : TC_W_M0;
    assign tc_ld = mode_q ? TC_LD_M1 : TC_LD_M0;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = W_L0;
            W_L0:      if (cnt == tc_w) next_state = W_TAIL;
            W_TAIL:    next_state = W_LOAD;
            W_LOAD:    if (cnt == tc_ld) next_state = GAP1;
            GAP1:      if (cnt == TC_GAP) next_state = A_L0;
            A_L0:      if (cnt == TC_LEN) next_state = A_TAIL;
            A_TAIL:    next_state = EXEC_PRE;
            EXEC_PRE:  next_state = EXEC;
            EXEC:      if (cnt == TC_LEN) next_state = GAP2;
            GAP2:      if (cnt == TC_GAP) next_state = WAIT_OV;
            WAIT_OV:   if (ofifo_valid) next_state = DRAIN_PRE;
            DRAIN_PRE: next_state = DRAIN;
            DRAIN:     if (cnt == TC_LEN) next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        counted = 1'b0;
        case (state)
            W_L0, W_LOAD, GAP1, A_L0, EXEC, GAP2, DRAIN: counted = 1'b1;
            default: counted = 1'b0;
        endcase
        next_cnt = (counted && next_state == state) ? cnt + 7'd1 : 7'd0;
    end

    // The word is computed for the state being entered so inst lines up with state.
    always_comb begin
        next_inst = IDLE_WORD;
        case (next_state)
            W_L0: begin
                next_inst[19]   = 1'b0;
                next_inst[17:7] = 11'd1024 + {4'd0, next_cnt};
                next_inst[2]    = 1'b1;
            end
            W_TAIL, A_TAIL: next_inst[2] = 1'b1;
            W_LOAD: begin
                next_inst[3] = 1'b1;
                next_inst[0] = 1'b1;
            end
            A_L0: begin
                next_inst[19]   = 1'b0;
                next_inst[17:7] = {4'd0, next_cnt};
                next_inst[2]    = 1'b1;
            end
            EXEC_PRE: next_inst[3] = 1'b1;
            EXEC: begin
                next_inst[3] = 1'b1;
                next_inst[1] = 1'b1;
            end
            DRAIN_PRE: next_inst[6] = 1'b1;
            DRAIN: begin
                next_inst[32]    = 1'b0;
                next_inst[31]    = 1'b0;
                next_inst[30:20] = base_q + {4'd0, next_cnt};
                next_inst[6]     = 1'b1;
            end
            default: next_inst = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 7'd0;
            mode_q <= 1'b0;
            base_q <= 11'd0;
            inst   <= IDLE_WORD;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            inst  <= next_inst;
            if (state == IDLE && start) begin
                mode_q <= mode;
                base_q <= pmem_base;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: a phase-list reference model builds the expected
// per-cycle instruction trace of a pass, and a vector table plus random passes exercise it.
module tb_inst_sequencer;

    localparam int COL = 8;
    localparam int LEN = 64;
    localparam int GAP = 10;
    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

    logic        clk = 1'b0;
    logic        reset, start, mode, ofifo_valid;
    logic [10:0] pmem_base;
    logic [33:0] inst;
    logic        busy, done;

    always #5 clk = ~clk;

    inst_sequencer #(.col(COL), .len_nij(LEN), .gap(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .pmem_base(pmem_base), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    typedef struct {
        logic [33:0] word;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        bit          mode;
        logic [10:0] base;
        int          wcyc;
        int          exp_done;
        int          start_kind;
    } vec_t;

    exp_t trace[$];
    int   prefix_len;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [33:0] mk(bit cen_p, bit wen_p, int a_p, bit cen_x, int a_x,
                                       bit of_rd, bit l0_rd, bit l0_wr, bit ex, bit ld);
        logic [33:0] w;
        w        = '0;
        w[32]    = cen_p;
        w[31]    = wen_p;
        w[30:20] = 11'(a_p);
        w[19]    = cen_x;
        w[18]    = 1'b1;
        w[17:7]  = 11'(a_x);
        w[6]     = of_rd;
        w[3]     = l0_rd;
        w[2]     = l0_wr;
        w[1]     = ex;
        w[0]     = ld;
        return w;
    endfunction

    task automatic push(logic [33:0] w);
        exp_t e;
        e.word = w;
        e.busy = 1'b1;
        e.done = 1'b0;
        trace.push_back(e);
    endtask

    // Expected trace, one entry per cycle following the start edge.
    task automatic build_trace(bit m, int base, int wcyc);
        int nw, nl;
        exp_t e;
        trace.delete();
        nw = m ? 2 * (COL + 1) : COL + 1;
        nl = m ? 4 * COL : 2 * COL;
        for (int k = 0; k < nw; k++) push(mk(1, 1, 0, 0, 1024 + k, 0, 0, 1, 0, 0));
        push(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < nl; k++) push(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 1));
        for (int k = 0; k < GAP; k++) push(IDLE_WORD);
        for (int k = 0; k < LEN; k++) push(mk(1, 1, 0, 0, k, 0, 0, 1, 0, 0));
        push(mk(1, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        push(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < LEN; k++) push(mk(1, 1, 0, 1, 0, 0, 1, 0, 1, 0));
        for (int k = 0; k < GAP; k++) push(IDLE_WORD);
        prefix_len = trace.size();
        for (int k = 0; k < wcyc; k++) push(IDLE_WORD);
        push(mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0));
        for (int k = 0; k < LEN; k++) push(mk(0, 0, (base + k) % 2048, 1, 0, 1, 0, 0, 0, 0));
        e.word = IDLE_WORD;
        e.busy = 1'b1;
        e.done = 1'b1;
        trace.push_back(e);
    endtask

    task automatic check_output(string name, int idx, logic [33:0] act, logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_idle(string name);
        check_output({name, "_inst"}, 0, inst, IDLE_WORD);
        check_output({name, "_busy"}, 0, 34'(busy), 34'd0);
        check_output({name, "_done"}, 0, 34'(done), 34'd0);
    endtask

    // start_kind: 0 = start low while busy, 1 = random start while busy,
    // 2 = start pulsed in A_L0 and in DONE.
    task automatic apply_stimulus(vec_t v);
        int done_idx, done_cnt, a_l0_idx, last;
        build_trace(v.mode, int'(v.base), v.wcyc);
        last     = trace.size() - 1;
        a_l0_idx = (v.mode ? 2 * (COL + 1) : COL + 1) + 1 + (v.mode ? 4 * COL : 2 * COL) + GAP + 5;
        done_idx = -1;
        done_cnt = 0;
        @(negedge clk);
        start       = 1'b1;
        mode        = v.mode;
        pmem_base   = v.base;
        ofifo_valid = 1'($urandom);
        @(posedge clk);
        #1;
        for (int i = 0; i <= last; i++) begin
            check_output("inst", i, inst, trace[i].word);
            check_output("busy", i, 34'(busy), 34'(trace[i].busy));
            check_output("done", i, 34'(done), 34'(trace[i].done));
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            case (v.start_kind)
                1:       start = 1'($urandom);
                2:       start = (i == a_l0_idx || i == last);
                default: start = 1'b0;
            endcase
            mode      = 1'($urandom);
            pmem_base = 11'($urandom);
            if (i < prefix_len || i > prefix_len + v.wcyc - 1) ofifo_valid = 1'($urandom);
            else ofifo_valid = (i == prefix_len + v.wcyc - 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_idle("post_pass");
        check_output("done_latency", 0, 34'(done_idx), 34'(v.exp_done));
        check_output("done_pulses", 0, 34'(done_cnt), 34'd1);
        @(posedge clk);
        #1;
        check_idle("post_pass2");
    endtask

    vec_t vecs[4];

    initial begin
        vec_t rv;
        int   exec_idx;
        vecs[0] = '{mode: 1'b0, base: 11'd0,    wcyc: 1,  exp_done: 242, start_kind: 2};
        vecs[1] = '{mode: 1'b1, base: 11'd0,    wcyc: 1,  exp_done: 267, start_kind: 0};
        vecs[2] = '{mode: 1'b0, base: 11'd0,    wcyc: 50, exp_done: 291, start_kind: 1};
        vecs[3] = '{mode: 1'b0, base: 11'd2000, wcyc: 1,  exp_done: 242, start_kind: 0};

        reset       = 1'b1;
        start       = 1'b1;
        mode        = 1'b1;
        pmem_base   = 11'd5;
        ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_idle("idle_no_start");

        for (int t = 0; t < 4; t++) apply_stimulus(vecs[t]);

        for (int t = 0; t < 4; t++) begin
            rv.mode       = 1'($urandom);
            rv.base       = 11'($urandom);
            rv.wcyc       = int'($urandom_range(1, 20));
            rv.exp_done   = 242 + 25 * int'(rv.mode) + rv.wcyc - 1;
            rv.start_kind = 1;
            apply_stimulus(rv);
        end

        // Reset in the middle of EXEC abandons the pass immediately.
        build_trace(1'b0, 0, 1);
        exec_idx = prefix_len - GAP - 30;
        @(negedge clk);
        start     = 1'b1;
        mode      = 1'b0;
        pmem_base = 11'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < exec_idx; i++) begin
            @(posedge clk);
            #1;
        end
        check_output("pre_reset_exec", exec_idx, inst, trace[exec_idx].word);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle("mid_exec_reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("after_reset_idle");
        rv = '{mode: 1'b0, base: 11'd100, wcyc: 3, exp_done: 244, start_kind: 0};
        apply_stimulus(rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no end expected end before time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
